// File: rtl/int_xbar_pkg.sv
// -----------------------------------------------------------------------------
// int_xbar_pkg
// Shared types and helpers for the interrupt crossbar.
//   int_mode_e  : per-source capture mode (level or rising edge)
//   idx_width() : claim index width, clog2 with a floor of 1
//   lowest_set(): index of the lowest set bit of a 64-bit vector (0 if none)
// -----------------------------------------------------------------------------
package int_xbar_pkg;

  localparam int MAX_SOURCES = 64;

  typedef enum logic {
    INT_LEVEL = 1'b0,
    INT_EDGE  = 1'b1
  } int_mode_e;

  // A single source still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Scans from the top down so the last hit is the lowest index; this
  // makes index 0 the highest priority.
  function automatic int lowest_set(input logic [MAX_SOURCES-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/int_sync_cell.sv
// -----------------------------------------------------------------------------
// int_sync_cell
// One interrupt source: synchroniser chain, optional rising-edge detection,
// pending flop and sticky overrun flag.
//   clock    : sole clock, rising edge
//   reset    : synchronous, active-low
//   raw      : raw interrupt input (asynchronous when SYNC_STAGES > 0)
//   clr      : claim of this source accepted this cycle
//   pending  : registered pending state
//   lost     : sticky overrun (edge mode only, constant 0 in level mode)
// Level mode: pending follows the synchronised input; clr is ignored because
// the source itself owns deassertion.
// Edge mode: a rising edge sets pending; clr drops it unless a new edge
// arrives in the same cycle (the new edge wins). An edge arriving while the
// previous one is still unclaimed sets lost until the next claim.
// -----------------------------------------------------------------------------
module int_sync_cell
  import int_xbar_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter int_mode_e MODE        = INT_LEVEL
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic clr,
  output logic pending,
  output logic lost
);

  logic s;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;

      always_ff @(posedge clock) begin
        if (!reset) begin
          chain <= '0;
        end else begin
          chain[0] <= raw;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            chain[k] <= chain[k-1];
          end
        end
      end

      assign s = chain[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Capture
  // ---------------------------------------------------------------------------
  generate
    if (MODE == INT_EDGE) begin : g_edge
      logic s_d;
      logic rise;

      always_ff @(posedge clock) begin
        if (!reset) s_d <= 1'b0;
        else        s_d <= s;
      end

      // After reset s_d is 0, so an input held high through reset yields
      // exactly one edge once the synchroniser fills.
      assign rise = s & ~s_d;

      always_ff @(posedge clock) begin
        if (!reset) begin
          pending <= 1'b0;
          lost    <= 1'b0;
        end else begin
          pending <= rise | (pending & ~clr);
          lost    <= (rise & pending & ~clr) | (lost & ~clr);
        end
      end
    end else begin : g_level
      // Claims of a level source are pure acknowledgements.
      logic unused_clr;
      assign unused_clr = clr;

      always_ff @(posedge clock) begin
        if (!reset) pending <= 1'b0;
        else        pending <= s;
      end

      assign lost = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/int_xbar_sync.sv
// -----------------------------------------------------------------------------
// int_xbar_sync
// Interrupt combining crossbar: NUM_IN sources are synchronised, captured as
// level or rising-edge pending, and presented with a fixed-priority claim
// port (lowest index wins).
//   clock        : sole clock, rising edge
//   reset        : synchronous, active-low
//   auto_int_in  : raw interrupt sources
//   int_mask     : 1 = source may be claimed (does not gate capture/output)
//   auto_int_out : registered pending vector
//   claim_valid  : some source is pending and enabled
//   claim_idx    : lowest pending-and-enabled index, 0 when claim_valid=0
//   claim_ready  : consumer accepts the current claim
//   lost         : sticky overrun flags (edge-mode sources only)
//
// Claim handshake: claim_valid/claim_idx are combinational from pending and
// int_mask only, never from claim_ready. A claim is taken on a rising clock
// edge where claim_valid && claim_ready; that edge clears the claimed edge
// source, and claim_idx moves to the next candidate in the following cycle.
// claim_ready may be held high with claim_valid low; nothing happens.
// -----------------------------------------------------------------------------
module int_xbar_sync
  import int_xbar_pkg::*;
#(
  parameter  int                NUM_IN      = 5,
  parameter  int                SYNC_STAGES = 2,
  parameter  logic [NUM_IN-1:0] EDGE_MASK   = '0,
  localparam int                IDX_W       = idx_width(NUM_IN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_IN-1:0] auto_int_in,
  input  logic [NUM_IN-1:0] int_mask,
  output logic [NUM_IN-1:0] auto_int_out,
  output logic              claim_valid,
  output logic [IDX_W-1:0]  claim_idx,
  input  logic              claim_ready,
  output logic [NUM_IN-1:0] lost
);

  logic [NUM_IN-1:0]      pending;
  logic [NUM_IN-1:0]      req;
  logic [NUM_IN-1:0]      clr;
  logic [MAX_SOURCES-1:0] req_ext;
  logic                   fire;

  // ---------------------------------------------------------------------------
  // Per-source cells
  // ---------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_IN; i++) begin : g_src
      int_sync_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .MODE        (EDGE_MASK[i] ? INT_EDGE : INT_LEVEL)
      ) u_cell (
        .clock   (clock),
        .reset   (reset),
        .raw     (auto_int_in[i]),
        .clr     (clr[i]),
        .pending (pending[i]),
        .lost    (lost[i])
      );
    end
  endgenerate

  assign auto_int_out = pending;

  // ---------------------------------------------------------------------------
  // Claim arbitration
  // ---------------------------------------------------------------------------
  assign req         = pending & int_mask;
  assign req_ext     = MAX_SOURCES'(req);
  assign claim_valid = |req;
  // lowest_set() returns 0 for an empty vector, so claim_idx is 0 when idle.
  assign claim_idx   = IDX_W'(lowest_set(req_ext));
  assign fire        = claim_valid & claim_ready;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      clr[i] = fire && (claim_idx == IDX_W'(i));
    end
  end

endmodule

// File: doc/int_xbar_sync.md
# int_xbar_sync

Parametrised interrupt crossbar that gathers NUM_IN asynchronous interrupt sources onto one flat output vector, as the interrupt-combining stage between device interrupt sources and the PLIC/CLINT-facing interrupt bus. Each source is synchronised, optionally converted from edge to pending-latched form, masked, and reported with a lowest-index-first claim handshake. Per-source overrun is tracked sticky until claimed.

## Interface
Parameters:
- NUM_IN, 5: number of interrupt sources (1..64); all per-source vectors are NUM_IN wide, bit i = source i.
- SYNC_STAGES, 2: synchroniser flops per source (0..3); 0 means inputs are already in the clock domain.
- EDGE_MASK, 0: NUM_IN-bit constant; bit i = 1 puts source i in rising-edge mode, 0 in level mode.
- IDX_W, $clog2(NUM_IN) (minimum 1): claim index width, derived, not overridden.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-low: reset==0 at a clock edge resets all state.
- auto_int_in  in  NUM_IN  raw interrupt sources, asynchronous to clock when SYNC_STAGES>0.
- int_mask  in  NUM_IN  1 = source enabled for claim; does not affect auto_int_out or pending capture.
- auto_int_out  out  NUM_IN  registered pending vector.
- claim_valid  out  1  at least one pending-and-enabled source.
- claim_idx  out  IDX_W  lowest index i with pending[i] & int_mask[i]; 0 when claim_valid=0.
- claim_ready  in  1  consumer accepts the current claim.
- lost  out  NUM_IN  sticky overrun flags (edge-mode sources only).

## Operation
- Per source: sync chain of SYNC_STAGES flops yields s[i]; previous-value flop s_d[i] <= s[i].
- Level mode: pending[i] <= s[i]. Claims do not clear it; the source owns deassertion.
- Edge mode: rise[i] = s[i] & ~s_d[i]; pending[i] <= rise[i] | (pending[i] & ~clr[i]).
- fire = claim_valid & claim_ready; clr[i] = fire & (claim_idx==i).
- Set and clear same cycle on one edge source: set wins, pending stays 1.
- lost[i] (edge mode) <= (rise[i] & pending[i] & ~clr[i]) | (lost[i] & ~clr[i]); level-mode lost bits are constant 0.
- claim_valid, claim_idx combinational from pending and int_mask; priority fixed, lowest index wins.
- int_mask changes take effect on claim outputs the same cycle.
- Claim of a level-mode source is a pure acknowledgement; no state changes.

## Timing
- Reset values: sync flops, s_d, pending, lost all 0; auto_int_out=0, claim_valid=0, claim_idx=0, lost=0 in the cycle after reset is sampled low.
- Edge source held high through reset: s rises from 0 after release and produces one edge (one pending).
- Reset asserted mid-operation discards all pending and lost state at that edge; no claim fires in that cycle regardless of claim_ready.
- Latency: input change sampled at edge k appears on auto_int_out after edge k+SYNC_STAGES (SYNC_STAGES+1 edges total); SYNC_STAGES=0 gives 1 cycle.
- Clear latency: fire at edge k drops pending from cycle k+1; claim_idx moves to next source in the same cycle pending updates.
- claim_valid must not depend on claim_ready (no combinational loop).
- Edge pulses shorter than one clock period are not guaranteed to be captured.

## Structure
- Package int_xbar_pkg: idx width function (clog2 with minimum 1), int_mode_e {INT_LEVEL, INT_EDGE}, lowest-set-bit priority function.
- Sub-module int_sync_cell: one source's sync chain, s_d flop, pending and lost flops; mode as parameter; inputs raw, clr; outputs pending, lost. Top instantiates NUM_IN cells via generate plus the priority/claim logic.

## Test plan
- Reset: drive auto_int_in=5'b11111, reset=0 two cycles -> all outputs 0; release, level sources reach auto_int_out after 3 edges (SYNC_STAGES=2).
- Level path, EDGE_MASK=0: raise in[3] at edge 10 -> auto_int_out[3]=1 from edge 12, claim_idx=3; fire -> pending remains 1; drop in[3] -> out[3]=0 three edges later.
- Edge priority, EDGE_MASK=5'b11111, int_mask=all 1: pulse in[1] and in[4] together -> claim_idx=1; fire -> claim_idx=4 next cycle; fire -> claim_valid=0.
- Overrun: edge-mode in[2] pulsed twice before claim -> lost[2]=1, pending[2]=1; one fire on idx 2 -> pending[2]=0, lost[2]=0.
- Set-beats-clear: new rise on in[0] lands the same cycle idx 0 fires -> pending[0] stays 1, lost[0] stays 0.
- Masking/reset mid-op: int_mask[0]=0 with pending[0]=1, pending[2]=1 -> claim_idx=2, auto_int_out[0]=1; assert reset with claim_ready=1 -> all state 0, no clear recorded.
